// File: rtl/fifo_pkg.sv
// Shared constants and types for the read side of the 32x8 synchronous FIFO.
// Pointers carry one extra wrap bit so full and empty can be told apart.
package fifo_pkg;

  localparam int FIFO_WIDTH   = 8;
  localparam int FIFO_DEPTH   = 32;
  localparam int PTR_W        = $clog2(FIFO_DEPTH) + 1;
  localparam int BURST_THRESH = 4;
  localparam int TIMEOUT      = 16;
  localparam int SKID_DEPTH   = 2;

  typedef logic [FIFO_WIDTH-1:0] fifo_word_t;
  typedef logic [PTR_W-1:0]      fifo_ptr_t;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } rd_state_e;

  // Occupancy from the two wrap-bit pointers; modulo arithmetic handles 63->0.
  function automatic fifo_ptr_t fifo_level(input fifo_ptr_t wp, input fifo_ptr_t rp);
    return fifo_ptr_t'(wp - rp);
  endfunction

endpackage

// File: rtl/fifo_skid_buf.sv
// Two-entry valid/ready buffer between the FIFO read port and the output stream.
// Entry 0 is always the head, so the output data is a plain register read.
module fifo_skid_buf
  import fifo_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  fifo_word_t push_data,
  input  logic       pop,
  output logic [1:0] count,
  output logic       out_valid,
  output fifo_word_t out_data
);

  fifo_word_t entry [SKID_DEPTH];
  logic       pop_ok;
  logic       push_ok;

  assign pop_ok  = pop && (count != 2'd0);
  assign push_ok = push && ((count != 2'(SKID_DEPTH)) || pop_ok);

  // NOTE: the entries are reset too, because the head register drives m_data
  // directly and must read zero straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry[0] <= '0;
      entry[1] <= '0;
      count    <= 2'd0;
    end else begin
      unique case ({push_ok, pop_ok})
        2'b10: begin
          entry[count[0]] <= push_data;
          count           <= count + 2'd1;
        end
        2'b01: begin
          entry[0] <= entry[1];
          count    <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            entry[0] <= push_data;
          end else begin
            entry[0] <= entry[1];
            entry[1] <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_valid = (count != 2'd0);
  assign out_data  = entry[0];

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    (push && (count == 2'(SKID_DEPTH))) |-> pop);

  a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
    pop |-> (count != 2'd0));

endmodule

// File: rtl/fifo_rd_ctrl.sv
// FIFO read-side controller: batches pops into drains, re-presents the words as
// a valid/ready stream through a 2-entry skid buffer and reports occupancy.
module fifo_rd_ctrl
  import fifo_pkg::*;
#(
  parameter int BURST_THRESH_P = BURST_THRESH,
  parameter int TIMEOUT_P      = TIMEOUT
) (
  input  logic             clk,
  input  logic             rstN,
  output logic             rd_en,
  input  logic             empty,
  input  fifo_word_t       data_out,
  input  logic [PTR_W-1:0] wrptr,
  input  logic [PTR_W-1:0] rdptr,
  output logic             m_valid,
  output fifo_word_t       m_data,
  input  logic             m_ready,
  output logic [PTR_W-1:0] level,
  output logic             lvl_err
);

  localparam int TIMER_W = $clog2(TIMEOUT_P);

  rd_state_e          state;
  rd_state_e          state_nxt;
  logic [TIMER_W-1:0] timer;
  logic               inflight;
  logic [1:0]         buf_count;
  logic [1:0]         credits;
  logic               pop;
  fifo_ptr_t          lvl_calc;
  logic               start_drain;
  logic               drain_done;

  assign lvl_calc = fifo_level(wrptr, rdptr);
  assign pop      = m_valid && m_ready;
  // Slots already claimed: words buffered plus the one still on its way back.
  assign credits  = buf_count + 2'(inflight);

  assign start_drain = (level >= PTR_W'(BURST_THRESH_P)) ||
                       (timer == TIMER_W'(TIMEOUT_P - 1));
  assign drain_done  = empty && !inflight && !rd_en;

  // NOTE: every register below uses non-blocking assignment so all of them
  // update together from pre-edge values, matching the synthesised flops.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: the default assignment ahead of the case keeps every path driven,
  // so no latch is inferred for state_nxt.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start_drain) state_nxt = DRAIN;
      DRAIN:   if (drain_done)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // A slot freed by this cycle's pop may be reclaimed in the same cycle.
  always_comb begin
    rd_en = 1'b0;
    if ((state == DRAIN) && !empty) begin
      rd_en = (credits < 2'd2) || ((credits == 2'd2) && pop);
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      timer <= '0;
    end else if (state_nxt == DRAIN) begin
      timer <= '0;
    end else if (empty) begin
      timer <= '0;
    end else begin
      timer <= timer + TIMER_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      inflight <= 1'b0;
    end else begin
      inflight <= rd_en;
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      level   <= '0;
      lvl_err <= 1'b0;
    end else begin
      level <= lvl_calc;
      if (lvl_calc > PTR_W'(FIFO_DEPTH)) begin
        lvl_err <= 1'b1;
      end
    end
  end

  fifo_skid_buf u_skid (
    .clk       (clk),
    .rst_n     (rstN),
    .push      (inflight),
    .push_data (data_out),
    .pop       (pop),
    .count     (buf_count),
    .out_valid (m_valid),
    .out_data  (m_data)
  );

  a_no_fifo_underflow: assert property (@(posedge clk) disable iff (!rstN)
    rd_en |-> !empty);

  a_credit_bound: assert property (@(posedge clk) disable iff (!rstN)
    credits <= 2'(SKID_DEPTH));

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Directed bench for fifo_rd_ctrl with a behavioural 32x8 FIFO model and an
// in-order scoreboard on the output stream.
module tb_fifo_rd_ctrl;
  import fifo_pkg::*;

  logic             clk = 1'b0;
  logic             rstN = 1'b0;
  logic             rd_en;
  logic             empty;
  fifo_word_t       data_out;
  logic [PTR_W-1:0] wrptr;
  logic [PTR_W-1:0] rdptr;
  logic             m_valid;
  fifo_word_t       m_data;
  logic             m_ready = 1'b1;
  logic [PTR_W-1:0] level;
  logic             lvl_err;

  // FIFO model and pointer override
  fifo_word_t       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wp = '0;
  logic [PTR_W-1:0] rp = '0;
  logic             wr_req = 1'b0;
  fifo_word_t       wr_data = '0;
  logic             fifo_clr = 1'b1;
  logic             ovr = 1'b0;
  logic [PTR_W-1:0] ovr_wp = '0;
  logic [PTR_W-1:0] ovr_rp = '0;

  fifo_word_t exp_q [$];
  logic       sb_on = 1'b1;
  int         rd_total = 0;
  int         viol = 0;
  int         n_chk = 0;
  int         n_bad = 0;

  always #5 clk = ~clk;

  assign wrptr = ovr ? ovr_wp : wp;
  assign rdptr = ovr ? ovr_rp : rp;
  assign empty = ovr ? 1'b1 : (wp == rp);

  always @(posedge clk) begin
    if (fifo_clr) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (wr_req) begin
        mem[wp[PTR_W-2:0]] <= wr_data;
        wp <= wp + 1'b1;
      end
      if (rd_en) begin
        data_out <= mem[rp[PTR_W-2:0]];
        rp <= rp + 1'b1;
      end
    end
  end

  fifo_rd_ctrl dut (
    .clk      (clk),
    .rstN     (rstN),
    .rd_en    (rd_en),
    .empty    (empty),
    .data_out (data_out),
    .wrptr    (wrptr),
    .rdptr    (rdptr),
    .m_valid  (m_valid),
    .m_data   (m_data),
    .m_ready  (m_ready),
    .level    (level),
    .lvl_err  (lvl_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rstN) begin
      if (rd_en) rd_total <= rd_total + 1;
      if (rd_en && empty) viol <= viol + 1;
      if (sb_on && m_valid && m_ready) begin
        check("sb_nonempty", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) check("sb_data", m_data, exp_q.pop_front());
      end
    end
  end

  task automatic write_burst(input int base, input int n);
    for (int i = 0; i < n; i++) begin
      wr_data = fifo_word_t'(base + i);
      wr_req  = 1'b1;
      exp_q.push_back(wr_data);
      @(posedge clk); #1;
    end
    wr_req = 1'b0;
  endtask

  task automatic do_reset();
    rstN = 1'b0;
    fifo_clr = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    fifo_clr = 1'b0;
    rstN = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int snap;
    logic found;
    logic [6:0] t1_rd;
    logic [6:0] t1_mv;
    fifo_word_t t1_dat [7];

    t1_rd  = 7'b0001111;   // bit i = cycle 6+i
    t1_mv  = 7'b0111100;
    t1_dat = '{8'h00, 8'h00, 8'h11, 8'h12, 8'h13, 8'h14, 8'h00};

    // Reset values
    #12;
    check("rst_rd_en", rd_en, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_level", level, 0);
    check("rst_lvl_err", lvl_err, 0);
    do_reset();

    // 1: threshold drain, back-to-back output
    write_burst('h11, 4);
    @(negedge clk); check("t1_level3", level, 3);
    @(negedge clk); check("t1_level4", level, 4);
    check("t1_no_rd_yet", rd_en, 0);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      check($sformatf("t1_rd_en_%0d", i), rd_en, t1_rd[i]);
      check($sformatf("t1_m_valid_%0d", i), m_valid, t1_mv[i]);
      if (t1_mv[i]) check($sformatf("t1_m_data_%0d", i), m_data, t1_dat[i]);
    end
    check("t1_idle", 32'(dut.state), 32'(IDLE));

    // 2: single word, timeout drain
    write_burst('hA5, 1);
    cnt = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (rd_en) cnt++;
    end
    check("t2_rd_held", cnt, 0);
    @(negedge clk); check("t2_rd_timeout", rd_en, 1);
    repeat (2) @(negedge clk);
    check("t2_m_valid", m_valid, 1);
    check("t2_m_data", m_data, 'hA5);
    repeat (3) @(negedge clk);
    check("t2_timer", 32'(dut.timer), 0);
    check("t2_idle", 32'(dut.state), 32'(IDLE));

    // 3: full FIFO under backpressure, then release
    @(posedge clk); #1;
    m_ready = 1'b0;
    snap = rd_total;
    write_burst('h20, 32);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (m_valid && (m_data != 8'h20)) cnt++;
    end
    @(posedge clk); #1;
    check("t3_rd_pulses", rd_total - snap, 2);
    check("t3_m_valid", m_valid, 1);
    check("t3_m_data_hold", m_data, 'h20);
    check("t3_unstable", cnt, 0);
    check("t3_level", level, 30);
    m_ready = 1'b1;
    cnt = 0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (!(m_valid && (m_data == fifo_word_t'('h20 + i)))) cnt++;
    end
    check("t3_stream_gaps", cnt, 0);
    repeat (3) @(negedge clk);
    check("t3_level_zero", level, 0);
    check("t3_drained", m_valid, 0);

    // 4: level from raw pointers, wrap and sticky error
    @(posedge clk); #1;
    ovr = 1'b1; ovr_wp = 6'd2; ovr_rp = 6'd62;
    @(posedge clk); @(negedge clk);
    check("t4_wrap_level", level, 4);
    check("t4_no_err", lvl_err, 0);
    check("t4_no_rd", rd_en, 0);
    @(posedge clk); #1;
    ovr_wp = 6'd40; ovr_rp = 6'd0;
    @(posedge clk); @(negedge clk);
    check("t4_level40", level, 40);
    check("t4_err_set", lvl_err, 1);
    @(posedge clk); #1;
    ovr_wp = 6'd0;
    repeat (3) @(negedge clk);
    check("t4_level0", level, 0);
    check("t4_err_sticky", lvl_err, 1);
    @(posedge clk); #1;
    ovr = 1'b0;
    do_reset();
    @(negedge clk); check("t4_err_cleared", lvl_err, 0);

    // 5: reset mid-drain with a read in flight
    sb_on = 1'b0;
    write_burst('h40, 6);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (rd_en) found = 1'b1;
    end
    check("t5_drain_seen", found, 1);
    @(posedge clk); #2;
    check("t5_inflight_pre", dut.inflight, 1);
    rstN = 1'b0;
    #1;
    check("t5_rd_en", rd_en, 0);
    check("t5_m_valid", m_valid, 0);
    check("t5_m_data", m_data, 0);
    check("t5_level", level, 0);
    check("t5_inflight", dut.inflight, 0);
    check("t5_state", 32'(dut.state), 32'(IDLE));
    fifo_clr = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    fifo_clr = 1'b0;
    @(posedge clk); #2;
    rstN = 1'b1;
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (m_valid || (m_data != 8'h00)) cnt++;
    end
    check("t5_no_stale", cnt, 0);

    // 6: random backpressure and writes, scoreboard checks order
    @(posedge clk); #1;
    sb_on = 1'b1;
    snap = viol;
    for (int i = 0; i < 500; i++) begin
      logic [PTR_W-1:0] occ;
      occ = wp - rp;
      m_ready = 1'($urandom_range(0, 1));
      if ((occ < 6'(FIFO_DEPTH)) && ($urandom_range(0, 2) == 0)) begin
        wr_data = fifo_word_t'($urandom);
        wr_req  = 1'b1;
        exp_q.push_back(wr_data);
      end else begin
        wr_req = 1'b0;
      end
      @(posedge clk); #1;
    end
    wr_req  = 1'b0;
    m_ready = 1'b1;
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge clk);
    @(posedge clk); #1;
    check("t6_all_delivered", exp_q.size(), 0);
    check("t6_no_underflow", viol - snap, 0);
    check("t6_total_underflow", viol, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
